// File: rtl/snn_load_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : snn_load_ctrl_if
// Function : Bundle of the loader's rx, input-RAM, snn_core and result signals.
// Revision : 1.0
// ============================================================================
interface snn_load_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int BYTE_W = 8
);
  logic              rx_rdy;
  logic [BYTE_W-1:0] rx_data;
  logic [ADDR_W-1:0] core_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_data;
  logic              ram_we;
  logic              snn_start;
  logic              snn_done;
  logic [3:0]        snn_digit;
  logic              busy;
  logic              result_vld;
  logic [3:0]        result_digit;
  logic              result_ack;
  logic              overrun;
  logic              timeout_err;

  // The loader itself sits on the slave side.
  modport slave (
    input  rx_rdy, rx_data, core_addr, snn_done, snn_digit, result_ack,
    output ram_addr, ram_data, ram_we, snn_start, busy, result_vld,
           result_digit, overrun, timeout_err
  );

  modport master (
    output rx_rdy, rx_data, core_addr, snn_done, snn_digit, result_ack,
    input  ram_addr, ram_data, ram_we, snn_start, busy, result_vld,
           result_digit, overrun, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/snn_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snn_load_ctrl
// Function : Unpacks received pixel bytes into the input RAM, starts snn_core,
//            latches its digit. Optional watchdog enabled by SNN_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module snn_load_ctrl #(
  parameter int NUM_PIXELS  = 784,
  parameter int ADDR_W      = 10,
  parameter int BYTE_W      = 8,
  parameter int TIMEOUT_CYC = 1048576
) (
  input wire             clk,
  input wire             rst_n,
  snn_load_ctrl_if.slave bus
);

  localparam int                  c_CNT_W    = $clog2(BYTE_W) + 1;
  localparam logic [c_CNT_W-1:0]  c_LAST_BIT = c_CNT_W'(BYTE_W - 1);
  localparam logic [ADDR_W-1:0]   c_LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

  if ((NUM_PIXELS % BYTE_W) != 0 || NUM_PIXELS > (1 << ADDR_W) || TIMEOUT_CYC < 2)
  begin : g_param_check
    $error("snn_load_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_UNPACK    = 3'd1,
    S_WAIT_BYTE = 3'd2,
    S_START     = 3'd3,
    S_COMPUTE   = 3'd4,
    S_RESULT    = 3'd5
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pix_cnt;
  logic [c_CNT_W-1:0]  r_bit_cnt;
  logic [BYTE_W-1:0]   r_shreg;
  logic                r_done_q;
  logic                r_ram_we;
  logic                r_snn_start;
  logic                r_busy;
  logic                r_result_vld;
  logic [3:0]          r_result_digit;
  logic                r_overrun;
  logic                w_done_rise;
  logic                w_wd_hit;

  assign w_done_rise = bus.snn_done & ~r_done_q;

  // r_ram_we is high exactly while unpacking, so it also selects the address owner.
  assign bus.ram_addr     = r_ram_we ? r_pix_cnt : bus.core_addr;
  assign bus.ram_data     = r_ram_we & r_shreg[0];
  assign bus.ram_we       = r_ram_we;
  assign bus.snn_start    = r_snn_start;
  assign bus.busy         = r_busy;
  assign bus.result_vld   = r_result_vld;
  assign bus.result_digit = r_result_digit;
  assign bus.overrun      = r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_pix_cnt      <= '0;
      r_bit_cnt      <= '0;
      r_shreg        <= '0;
      r_done_q       <= 1'b0;
      r_ram_we       <= 1'b0;
      r_snn_start    <= 1'b0;
      r_busy         <= 1'b0;
      r_result_vld   <= 1'b0;
      r_result_digit <= 4'd0;
      r_overrun      <= 1'b0;
    end else begin
      r_done_q    <= bus.snn_done;
      r_snn_start <= 1'b0;
      case (r_state)
        S_IDLE, S_WAIT_BYTE: begin
          if (bus.rx_rdy) begin
            r_shreg   <= bus.rx_data;
            r_bit_cnt <= '0;
            r_ram_we  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_UNPACK;
          end else if (w_wd_hit) begin
            r_pix_cnt <= '0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_UNPACK: begin
          r_shreg   <= r_shreg >> 1;
          r_pix_cnt <= r_pix_cnt + 1'b1;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (bus.rx_rdy) r_overrun <= 1'b1;
          if (r_bit_cnt == c_LAST_BIT) begin
            r_ram_we <= 1'b0;
            if (r_pix_cnt == c_LAST_PIX) begin
              r_snn_start <= 1'b1;
              r_state     <= S_START;
            end else begin
              r_state <= S_WAIT_BYTE;
            end
          end
        end
        S_START: begin
          r_pix_cnt <= '0;
          if (bus.rx_rdy) r_overrun <= 1'b1;
          r_state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          if (bus.rx_rdy) r_overrun <= 1'b1;
          if (w_done_rise) begin
            r_result_digit <= bus.snn_digit;
            r_result_vld   <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= S_RESULT;
          end else if (w_wd_hit) begin
            r_pix_cnt <= '0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_RESULT: begin
          // Acknowledge wins over a coincident byte: it is dropped without flagging overrun.
          if (bus.result_ack) begin
            r_result_vld <= 1'b0;
            r_overrun    <= 1'b0;
            r_state      <= S_IDLE;
          end else if (bus.rx_rdy) begin
            r_overrun <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SNN_TIMEOUT_EN
  localparam int                c_WD_W    = $clog2(TIMEOUT_CYC);
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYC - 1);

  logic [c_WD_W-1:0] r_wd_cnt;
  logic              r_timeout_err;
  logic              w_wd_run;

  // Leaving the watched states clears the count, so every entry starts from zero.
  assign w_wd_run = (r_state == S_WAIT_BYTE) || (r_state == S_COMPUTE);
  assign w_wd_hit = w_wd_run && !bus.rx_rdy && (r_wd_cnt == c_WD_LAST) &&
                    !((r_state == S_COMPUTE) && w_done_rise);
  assign bus.timeout_err = r_timeout_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (!w_wd_run || bus.rx_rdy) r_wd_cnt <= '0;
      else                         r_wd_cnt <= r_wd_cnt + 1'b1;
      if (w_wd_hit)
        r_timeout_err <= 1'b1;
      else if ((r_state == S_RESULT && bus.result_ack) ||
               (r_state == S_IDLE && bus.rx_rdy))
        r_timeout_err <= 1'b0;
    end
  end
`else
  assign w_wd_hit        = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_snn_load_ctrl.sv
`default_nettype none
// Bench for snn_load_ctrl: write/result scoreboard fed by directed image loads,
// plus a simple snn_core model that can sweep core_addr while computing.
module tb_snn_load_ctrl;
  localparam int NUM_PIXELS  = 784;
  localparam int ADDR_W      = 10;
  localparam int BYTE_W      = 8;
  localparam int TIMEOUT_CYC = 100;
  localparam int GAP         = 20;
  localparam logic [ADDR_W-1:0] IDLE_CORE_ADDR = 10'h155;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snn_load_ctrl_if #(.ADDR_W(ADDR_W), .BYTE_W(BYTE_W)) bus ();

  snn_load_ctrl #(
    .NUM_PIXELS (NUM_PIXELS),
    .ADDR_W     (ADDR_W),
    .BYTE_W     (BYTE_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         tb_pix   = 0;
  int         start_cnt = 0;
  int         last_rx_cyc = 0;
  int         start_cyc = 0;
  int         done_cyc = 0;
  int         sweep_err = 0;
  int         core_delay = 50;
  logic [3:0] core_digit = 4'd0;
  bit         core_sweep = 1'b0;
  logic       vld_q = 1'b0;
  logic       done_q = 1'b0;
  wr_t        exp_wr[$];
  logic [3:0] exp_res[$];
  wr_t        got_w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected RAM writes and results whenever the DUT presents one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_rdy) last_rx_cyc = cyc;
      if (bus.snn_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (bus.snn_done && !done_q) done_cyc = cyc;
      if (bus.ram_we) begin
        check("wr_pending", 32'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) begin
          got_w = exp_wr.pop_front();
          check("wr_addr", 32'(bus.ram_addr), 32'(got_w.addr));
          check("wr_data", 32'(bus.ram_data), 32'(got_w.data));
        end
      end
      if (bus.result_vld && !vld_q) begin
        check("result_pending", 32'(exp_res.size() != 0), 1);
        if (exp_res.size() != 0) begin
          check("result_digit", 32'(bus.result_digit), 32'(exp_res.pop_front()));
          check("done_to_vld_latency", 32'(cyc - done_cyc), 1);
        end
      end
    end
    vld_q  = bus.result_vld;
    done_q = bus.snn_done;
  end

  // snn_core model: answers each start after core_delay cycles, optionally sweeping core_addr.
  initial begin : core_model
    bus.snn_done  = 1'b0;
    bus.snn_digit = 4'd0;
    bus.core_addr = IDLE_CORE_ADDR;
    forever begin
      @(negedge clk);
      if (rst_n && bus.snn_start) begin
        for (int i = 0; i < core_delay; i++) begin
          @(posedge clk);
          #1 if (core_sweep && i < NUM_PIXELS) bus.core_addr = ADDR_W'(i);
          @(negedge clk);
          if (core_sweep && i < NUM_PIXELS &&
              (bus.ram_addr !== bus.core_addr || bus.ram_we !== 1'b0)) sweep_err++;
        end
        @(posedge clk);
        #1 bus.snn_done = 1'b1;
        bus.snn_digit = core_digit;
        @(posedge clk);
        #1 bus.snn_done = 1'b0;
        bus.core_addr = IDLE_CORE_ADDR;
      end
    end
  end

  task automatic pulse_rx(input logic [BYTE_W-1:0] d);
    @(posedge clk);
    #1 bus.rx_rdy = 1'b1;
    bus.rx_data = d;
    @(posedge clk);
    #1 bus.rx_rdy = 1'b0;
  endtask

  task automatic load_image(input int nbytes, input logic [7:0] base,
                            input logic [7:0] step, input int drop_after);
    logic [7:0] d;
    wr_t        w;
    for (int b = 0; b < nbytes; b++) begin
      d = base + 8'(b) * step;
      for (int k = 0; k < BYTE_W; k++) begin
        w.addr = ADDR_W'(tb_pix + k);
        w.data = d[k];
        exp_wr.push_back(w);
      end
      tb_pix += BYTE_W;
      pulse_rx(d);
      if (b == drop_after) begin
        @(posedge clk);
        pulse_rx(8'hFF);
        @(negedge clk);
        check("overrun_on_drop", 32'(bus.overrun), 1);
        check("busy_in_unpack", 32'(bus.busy), 1);
      end
      repeat (GAP) @(posedge clk);
    end
  endtask

  task automatic wait_start(input int expected);
    for (int i = 0; i < 64 && start_cnt < expected; i++) @(negedge clk);
    check("snn_start_count", 32'(start_cnt), 32'(expected));
    check("load_latency", 32'(start_cyc - last_rx_cyc), 32'(BYTE_W + 1));
  endtask

  task automatic wait_vld(input int budget);
    for (int i = 0; i < budget && !bus.result_vld; i++) @(negedge clk);
    check("result_vld_seen", 32'(bus.result_vld), 1);
  endtask

  task automatic ack_result(input bit with_rx);
    @(posedge clk);
    #1 bus.result_ack = 1'b1;
    if (with_rx) begin
      bus.rx_rdy  = 1'b1;
      bus.rx_data = 8'hFF;
    end
    @(posedge clk);
    #1 bus.result_ack = 1'b0;
    bus.rx_rdy = 1'b0;
    @(negedge clk);
    check("vld_after_ack", 32'(bus.result_vld), 0);
    check("overrun_after_ack", 32'(bus.overrun), 0);
    check("busy_after_ack", 32'(bus.busy), 0);
    check("timeout_after_ack", 32'(bus.timeout_err), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.rx_rdy     = 1'b0;
    bus.rx_data    = '0;
    bus.result_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram_we", 32'(bus.ram_we), 0);
    check("rst_ram_data", 32'(bus.ram_data), 0);
    check("rst_snn_start", 32'(bus.snn_start), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_result_vld", 32'(bus.result_vld), 0);
    check("rst_result_digit", 32'(bus.result_digit), 0);
    check("rst_overrun", 32'(bus.overrun), 0);
    check("rst_timeout_err", 32'(bus.timeout_err), 0);
    check("rst_ram_addr_is_core", 32'(bus.ram_addr), 32'(IDLE_CORE_ADDR));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Load 1: constant 0xA5 bytes, one extra byte dropped mid-unpack.
    core_delay = 50; core_digit = 4'd7; core_sweep = 1'b0;
    exp_res.push_back(4'd7);
    tb_pix = 0;
    load_image(98, 8'hA5, 8'd0, 4);
    wait_start(1);
    wait_vld(200);
    repeat (10) @(negedge clk);
    check("vld_held", 32'(bus.result_vld), 1);
    check("digit_held", 32'(bus.result_digit), 7);
    check("busy_in_result", 32'(bus.busy), 0);
    check("overrun_sticky", 32'(bus.overrun), 1);
    ack_result(1'b0);

    // Load 2: varying bytes, core sweeps core_addr while computing.
    core_delay = 800; core_digit = 4'd3; core_sweep = 1'b1; sweep_err = 0;
    exp_res.push_back(4'd3);
    tb_pix = 0;
    load_image(98, 8'h01, 8'd37, -1);
    wait_start(2);
    wait_vld(1000);
    check("compute_addr_sweep_errors", 32'(sweep_err), 0);
    ack_result(1'b1);

    // Load 3: aborted by reset after 40 bytes, then a fresh full load.
    core_delay = 50; core_digit = 4'd9; core_sweep = 1'b0;
    tb_pix = 0;
    load_image(40, 8'h5A, 8'd3, -1);
    check("partial_load_drained", 32'(exp_wr.size()), 0);
    check("busy_before_abort", 32'(bus.busy), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_ram_we", 32'(bus.ram_we), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_res.push_back(4'd9);
    tb_pix = 0;
    load_image(98, 8'h3C, 8'd0, -1);
    wait_start(3);
    wait_vld(200);
    ack_result(1'b0);

`ifdef SNN_TIMEOUT_EN
    tb_pix = 0;
    load_image(10, 8'h0F, 8'd0, -1);
    repeat (80) @(posedge clk);
    @(negedge clk);
    check("wd_not_yet", 32'(bus.timeout_err), 0);
    check("wd_busy_waiting", 32'(bus.busy), 1);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("wd_fired", 32'(bus.timeout_err), 1);
    check("wd_busy_idle", 32'(bus.busy), 0);
    check("wd_no_result", 32'(bus.result_vld), 0);
    tb_pix = 0;
    load_image(1, 8'h81, 8'd0, -1);
    check("wd_cleared_by_rx", 32'(bus.timeout_err), 0);
    check("wd_restart_busy", 32'(bus.busy), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
`endif

    repeat (5) @(posedge clk);
    check("writes_all_seen", 32'(exp_wr.size()), 0);
    check("results_all_seen", 32'(exp_res.size()), 0);
    check("total_starts", 32'(start_cnt), 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
